refresh_sequencer: RTL and testbench
====================================

Name: refresh_sequencer

Overview:
- Responder end of the ref_req/ref_ack refresh handshake. Sits between the refresh request generator and the DDR3 command bus mux.
- On a request it quiesces normal traffic and closes open banks with PRECHARGE ALL. It then issues REFRESH, returns ref_ack when REFRESH is accepted, and holds off traffic until tRFC has elapsed.
- Also keeps a wrapping count of completed refreshes for debug.

Parameters:
- TW, 16, width of timing inputs and the internal wait timer.
- CW, 16, width of the completed-refresh counter.
- SKIP_PREA, 1, when 1, PRECHARGE ALL is omitted if no bank is open at drain completion.

Ports:
- clk  in  1  controller clock.
- reset_n  in  1  asynchronous active-low reset.
- ref_req  in  1  refresh request, level, held until acked.
- ref_ack  out  1  one-cycle pulse on the cycle REFRESH is accepted on the command bus.
- traffic_idle  in  1  no read/write burst in flight, and the scheduler has no command mid-issue.
- any_bank_open  in  1  OR of the per-bank open-row flags.
- hold_req  out  1  scheduler must not issue ACT/RD/WR/PRE while high.
- cmd_valid  out  1  command offered to the bus mux.
- cmd_code  out  3  CMD_NOP / CMD_PREA / CMD_REF.
- cmd_ready  in  1  bus mux accepted the command this cycle.
- tRP  in  TW  precharge-to-refresh delay, in cycles.
- tRFC  in  TW  refresh cycle time, in cycles.
- busy  out  1  state != IDLE.
- refresh_done  out  1  one-cycle pulse on the last tRFC cycle.
- ref_count  out  CW  completed refreshes, wraps modulo 2^CW.

Behaviour:
- Reset values:
  - All outputs are 0; cmd_code = CMD_NOP; state = IDLE; timer = 0.
  - Reset asserted mid-sequence aborts immediately. No ack is issued.
- States: IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC. The encoding lives in the package.
- IDLE:
  - On ref_req=1, go to DRAIN on the next edge.
  - hold_req and busy rise in the DRAIN cycle, i.e. one cycle after ref_req is sampled.
- DRAIN:
  - hold_req=1. Stay while traffic_idle=0.
  - If ref_req drops here, return to IDLE and drop hold_req. This is the only abort point.
  - When traffic_idle=1: if any_bank_open=1 or SKIP_PREA=0, go to PREA; otherwise go to REF.
- PREA:
  - cmd_valid=1, cmd_code=CMD_PREA, held stable until cmd_ready.
  - On acceptance, load timer with max(tRP,1) and go to WAIT_RP.
- WAIT_RP:
  - cmd_valid=0. Decrement timer each cycle.
  - When timer==1, go to REF next edge. WAIT_RP therefore lasts exactly max(tRP,1) cycles.
- REF:
  - cmd_valid=1, cmd_code=CMD_REF, held until cmd_ready.
  - In the acceptance cycle, ref_ack=1 (combinational on cmd_valid&&cmd_ready&&state==REF).
  - Also on acceptance: load timer with max(tRFC,1) and go to WAIT_RFC.
  - ref_ack is pulsed exactly once per sequence.
- WAIT_RFC:
  - hold_req=1, decrement timer.
  - When timer==1: refresh_done=1 that cycle, ref_count increments, and the next state is IDLE.
  - A ref_req seen while in WAIT_RFC is ignored. It is sampled again only in IDLE, so back-to-back refreshes are separated by at least one IDLE cycle.
- cmd_valid never deasserts before cmd_ready. cmd_code is CMD_NOP whenever cmd_valid=0.
- tRP/tRFC are sampled only at timer load. Changes mid-wait have no effect.
- ref_count wraps from 2^CW-1 to 0 with no flag.

Decomposition:
- Shared package ddr3_ctrl_pkg holds:
  - the cmd_code enum: CMD_NOP=3'd0, CMD_PREA=3'd1, CMD_REF=3'd2 (the remaining codes are reserved for the scheduler);
  - the refresh state enum;
  - the default TW.
- One natural sub-module, timing_down_counter: TW-bit loadable down-counter with a load input, a value input and an expire (==1) flag. It is reused for both tRP and tRFC waits and by the scheduler for other timings.

Test Plan:
- Basic path: tRP=4, tRFC=10, any_bank_open=1, traffic_idle=1, cmd_ready=1, raise ref_req at cycle 0.
  - hold_req rises at cycle 1; PREA is accepted at cycle 2.
  - REF is accepted with ref_ack at cycle 7, after 4 WAIT_RP cycles.
  - refresh_done pulses at cycle 17; busy drops at cycle 18; ref_count=1.
- Skip path: any_bank_open=0, SKIP_PREA=1.
  - No CMD_PREA appears; REF is issued in the cycle after DRAIN; ref_ack is a single pulse.
- Drain stall and abort:
  - traffic_idle=0 for 6 cycles, then 1: PREA is delayed by exactly 6 cycles and hold_req is high throughout.
  - Separately, drop ref_req in DRAIN: the block returns to IDLE with no command and no ack.
- Back-pressure: cmd_ready=0 for 3 cycles in PREA and 2 in REF.
  - cmd_valid/cmd_code stay stable; ref_ack fires only in the accept cycle; timers start after acceptance.
- Boundaries:
  - tRP=0 and tRFC=0 behave as 1-cycle waits.
  - Run 2^CW+1 sequences with CW=4: ref_count reads 1.
  - A ref_req held high through WAIT_RFC starts a new sequence only after one IDLE cycle.
- Async reset asserted during WAIT_RFC: all outputs are 0 immediately, no refresh_done, and the state is IDLE after release.

Source files
------------

// File: rtl/ddr3_ctrl_pkg.sv
// Shared DDR3 controller definitions: command codes, refresh FSM encoding, default widths.
package ddr3_ctrl_pkg;

  localparam int TW_DEFAULT = 16;

  // Codes 3..7 are reserved for the scheduler's own commands.
  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PREA = 3'd1,
    CMD_REF  = 3'd2
  } cmd_code_e;

  typedef logic [2:0] ref_state_t;

  localparam ref_state_t ST_IDLE     = 3'd0;
  localparam ref_state_t ST_DRAIN    = 3'd1;
  localparam ref_state_t ST_PREA     = 3'd2;
  localparam ref_state_t ST_WAIT_RP  = 3'd3;
  localparam ref_state_t ST_REF      = 3'd4;
  localparam ref_state_t ST_WAIT_RFC = 3'd5;

endpackage

// File: rtl/refresh_sequencer_timing_down_counter.sv
// Loadable down-counter shared by all DRAM timing waits; expire flags the last wait cycle.
module timing_down_counter
  import ddr3_ctrl_pkg::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          expire
);

  logic [TW-1:0] count_q, count_d;

  // Counts down to zero and parks there until the next load.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == TW'(1));

endmodule

// File: rtl/refresh_sequencer.sv
// Refresh handshake responder: drain traffic, PRECHARGE ALL, REFRESH, then hold off for tRFC.
module refresh_sequencer
  import ddr3_ctrl_pkg::*;
#(
  parameter int TW        = TW_DEFAULT,
  parameter int CW        = 16,
  parameter bit SKIP_PREA = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ref_req,
  output logic          ref_ack,
  input  logic          traffic_idle,
  input  logic          any_bank_open,
  output logic          hold_req,
  output logic          cmd_valid,
  output logic [2:0]    cmd_code,
  input  logic          cmd_ready,
  input  logic [TW-1:0] tRP,
  input  logic [TW-1:0] tRFC,
  output logic          busy,
  output logic          refresh_done,
  output logic [CW-1:0] ref_count
);

  ref_state_t    state_q, state_d;
  logic [CW-1:0] ref_count_q, ref_count_d;
  logic          timer_load;
  logic          timer_expire;
  logic [TW-1:0] timer_value;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ref_req) state_d = ST_DRAIN;
      // Dropping the request is honoured only before any command goes out.
      ST_DRAIN: begin
        if (!ref_req) begin
          state_d = ST_IDLE;
        end else if (traffic_idle) begin
          state_d = (any_bank_open || !SKIP_PREA) ? ST_PREA : ST_REF;
        end
      end
      ST_PREA:     if (cmd_ready) state_d = ST_WAIT_RP;
      ST_WAIT_RP:  if (timer_expire) state_d = ST_REF;
      ST_REF:      if (cmd_ready) state_d = ST_WAIT_RFC;
      ST_WAIT_RFC: if (timer_expire) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Zero timings are clamped to one cycle so the wait states always exit.
  assign timer_load  = cmd_ready && ((state_q == ST_PREA) || (state_q == ST_REF));
  assign timer_value = (state_q == ST_PREA) ? ((tRP  == '0) ? TW'(1) : tRP)
                                            : ((tRFC == '0) ? TW'(1) : tRFC);

  timing_down_counter #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (timer_expire)
  );

  assign busy         = (state_q != ST_IDLE);
  assign hold_req     = busy;
  assign cmd_valid    = (state_q == ST_PREA) || (state_q == ST_REF);
  assign cmd_code     = (state_q == ST_PREA) ? CMD_PREA :
                        (state_q == ST_REF)  ? CMD_REF  : CMD_NOP;
  assign ref_ack      = cmd_valid && cmd_ready && (state_q == ST_REF);
  assign refresh_done = (state_q == ST_WAIT_RFC) && timer_expire;
  assign ref_count    = ref_count_q;

  assign ref_count_d  = ref_count_q + CW'(refresh_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ref_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_count_q <= ref_count_d;
    end
  end

endmodule

// File: tb/tb_refresh_sequencer.sv
// Directed self-checking bench for refresh_sequencer (CW=4 so the counter wrap is reachable).
module tb_refresh_sequencer;
  import ddr3_ctrl_pkg::*;

  localparam int TW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ref_req = 1'b0;
  logic          traffic_idle = 1'b0;
  logic          any_bank_open = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [TW-1:0] tRP = '0;
  logic [TW-1:0] tRFC = '0;
  logic          ref_ack, hold_req, cmd_valid, busy, refresh_done;
  logic [2:0]    cmd_code;
  logic [CW-1:0] ref_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  refresh_sequencer #(.TW(TW), .CW(CW), .SKIP_PREA(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ref_req       (ref_req),
    .ref_ack       (ref_ack),
    .traffic_idle  (traffic_idle),
    .any_bank_open (any_bank_open),
    .hold_req      (hold_req),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_ready     (cmd_ready),
    .tRP           (tRP),
    .tRFC          (tRFC),
    .busy          (busy),
    .refresh_done  (refresh_done),
    .ref_count     (ref_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".hold_req"}, int'(hold_req), 0);
    check({tag, ".cmd_valid"}, int'(cmd_valid), 0);
    check({tag, ".cmd_code"}, int'(cmd_code), int'(CMD_NOP));
    check({tag, ".ref_ack"}, int'(ref_ack), 0);
    check({tag, ".refresh_done"}, int'(refresh_done), 0);
    check({tag, ".ref_count"}, int'(ref_count), 0);
  endtask

  // Runs one refresh sequence starting in IDLE; cycle 0 is the cycle ref_req is raised.
  // d = traffic_idle low cycles in DRAIN, ps/rs = cmd_ready low cycles in PREA/REF.
  task automatic run_seq(input string name, input int trp, input int trfc, input bit bank,
                         input int d, input int ps, input int rs, input bit keep,
                         output int busy_c);
    int hold_c, prea_c, ack_c, done_c, ack_n, prea_n, done_n, viol, pw, rw;
    int r, f, base;
    logic pv_valid, pv_ready;
    logic [2:0] pv_code;
    hold_c = -1; prea_c = -1; ack_c = -1; done_c = -1; busy_c = -1;
    ack_n = 0; prea_n = 0; done_n = 0; viol = 0; pw = 0; rw = 0;
    pv_valid = 1'b0; pv_ready = 1'b0; pv_code = 3'd0;
    tRP = TW'(trp); tRFC = TW'(trfc); any_bank_open = bank;
    traffic_idle = (d == 0); cmd_ready = 1'b0; ref_req = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      // Timing inputs change after their load edge and must not affect the wait.
      if (c == prea_c + 1) tRP = TW'(trp + 7);
      if (c == ack_c + 1) tRFC = TW'(trfc + 9);
      traffic_idle = (c > d);
      cmd_ready = 1'b0;
      if (cmd_valid && cmd_code == CMD_PREA) begin cmd_ready = (pw >= ps); pw++; end
      if (cmd_valid && cmd_code == CMD_REF)  begin cmd_ready = (rw >= rs); rw++; end
      #1;
      if (hold_c < 0 && hold_req) hold_c = c;
      if (hold_req !== busy) viol++;
      if (!cmd_valid && cmd_code !== CMD_NOP) viol++;
      if (pv_valid && !pv_ready && (!cmd_valid || cmd_code !== pv_code)) viol++;
      if (ref_ack && !(cmd_valid && cmd_ready && cmd_code == CMD_REF)) viol++;
      if (cmd_valid && cmd_ready && cmd_code == CMD_PREA) begin prea_n++; prea_c = c; end
      if (ref_ack) begin
        ack_n++; ack_c = c;
        if (!keep) ref_req = 1'b0;
      end
      if (refresh_done) begin done_n++; done_c = c; end
      pv_valid = cmd_valid; pv_ready = cmd_ready; pv_code = cmd_code;
      if (!busy) begin busy_c = c; break; end
    end
    cmd_ready = 1'b0;
    r = (trp == 0) ? 1 : trp;
    f = (trfc == 0) ? 1 : trfc;
    base = bank ? (d + 3 + ps + r + rs) : (d + 2 + rs);
    exp_cnt = (exp_cnt + 1) % 16;
    check({name, ".hold_rise_cycle"}, hold_c, 1);
    check({name, ".prea_count"}, prea_n, int'(bank));
    if (bank) check({name, ".prea_accept_cycle"}, prea_c, d + 2 + ps);
    check({name, ".ack_count"}, ack_n, 1);
    check({name, ".ack_cycle"}, ack_c, base);
    check({name, ".done_count"}, done_n, 1);
    check({name, ".done_cycle"}, done_c, base + f);
    check({name, ".busy_drop_cycle"}, busy_c, base + f + 1);
    check({name, ".protocol_violations"}, viol, 0);
    check({name, ".ref_count"}, int'(ref_count), exp_cnt);
  endtask

  initial begin
    int bc;
    int done_seen;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check_all_zero("after_reset");

    run_seq("basic", 4, 10, 1'b1, 0, 0, 0, 1'b0, bc);
    run_seq("skip_prea", 4, 10, 1'b0, 0, 0, 0, 1'b0, bc);
    run_seq("drain_stall", 4, 10, 1'b1, 6, 0, 0, 1'b0, bc);
    run_seq("backpressure", 2, 3, 1'b1, 0, 3, 2, 1'b0, bc);
    run_seq("zero_timing", 0, 0, 1'b1, 0, 0, 0, 1'b0, bc);

    // ref_req held through WAIT_RFC: one IDLE cycle, then DRAIN again.
    run_seq("back_to_back", 3, 2, 1'b1, 0, 0, 0, 1'b1, bc);
    check("b2b.idle_cycle_busy", int'(busy), 0);
    tick();
    check("b2b.restart_busy", int'(busy), 1);
    ref_req = 1'b0;
    tick();
    check("b2b.abort_busy", int'(busy), 0);

    // Abort from DRAIN even with traffic_idle high.
    ref_req = 1'b1; traffic_idle = 1'b0; any_bank_open = 1'b1; cmd_ready = 1'b1;
    tick();
    check("abort.drain_hold", int'(hold_req), 1);
    check("abort.drain_cmd_valid", int'(cmd_valid), 0);
    ref_req = 1'b0; traffic_idle = 1'b1;
    tick();
    check("abort.idle_busy", int'(busy), 0);
    check("abort.idle_hold", int'(hold_req), 0);
    check("abort.idle_cmd_valid", int'(cmd_valid), 0);
    check("abort.ref_ack", int'(ref_ack), 0);
    check("abort.ref_count", int'(ref_count), exp_cnt);
    cmd_ready = 1'b0;

    // Eleven more sequences bring the total to 17 = 2^4 + 1.
    for (int i = 0; i < 11; i++) run_seq("wrap_run", 0, 0, 1'b0, 0, 0, 0, 1'b0, bc);
    check("wrap.ref_count_17", int'(ref_count), 1);

    // Async reset during WAIT_RFC.
    tRP = TW'(1); tRFC = TW'(20); any_bank_open = 1'b1; traffic_idle = 1'b1;
    cmd_ready = 1'b1; ref_req = 1'b1;
    repeat (8) tick();
    check("async.in_wait_rfc_busy", int'(busy), 1);
    check("async.in_wait_rfc_cmd_valid", int'(cmd_valid), 0);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    ref_req = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (refresh_done) done_seen++;
    end
    check("async.no_refresh_done", done_seen, 0);
    #2 reset_n = 1'b1;
    tick();
    check_all_zero("async_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
